fetch_stage: RTL and testbench

Instruction fetch stage of the rv32i core. Holds the program counter and drives the combinational instruction memory with a byte address. Captures each returned word with its PC into a small fetch queue. Presents the queue head to decode through a valid/ready handshake; a redirect from execute (taken branch/jump) re-steers the PC and flushes the queue.

---
 rtl/rv32i_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 34 +++
 rtl/fetch_stage.sv | 48 ++++
 tb/tb_fetch_stage.sv | 124 ++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared rv32i constants and the fetch queue entry layout {pc, instr}
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry fetch queue with push/pop/flush (flush wins), full/empty flags and head entry
module fetch_fifo import rv32i_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] count;
  assign head = mem[rd];
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr] <= wdata;
      wr <= wr + AW'(push);
      rd <= rd + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: rv32i PC register, imem addressing, fetch queue to decode via valid/ready, redirect flush and misaligned pulse
module fetch_stage import rv32i_pkg::XLEN, rv32i_pkg::fetch_entry_t; #(
  parameter logic [XLEN-1:0] RESET_PC = rv32i_pkg::RESET_PC,
  parameter int DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            misaligned
);
  logic [XLEN-1:0] pc;
  logic push, pop, full, empty;
  fetch_entry_t head;
  assign imem_addr = pc;
  assign out_valid = !empty;
  assign pop = out_valid && out_ready && !redirect_valid;
  assign push = !redirect_valid && (!full || pop);
  assign out_pc = empty ? '0 : head.pc;
  assign out_instr = empty ? NOP_INSTR : head.instr;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .wdata('{pc: pc, instr: imem_rdata}),
    .head(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      misaligned <= redirect_valid && |redirect_pc[1:0];
      pc <= redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : push ? pc + 32'd4 : pc;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 0, rst_n = 0, redirect_valid = 0, out_ready = 0;
  logic [31:0] imem_addr, imem_rdata, redirect_pc = 0, out_pc, out_instr;
  logic out_valid, misaligned;
  int tests = 0, fails = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr | 32'hA000_0000;
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .misaligned(misaligned)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0; out_ready = 0; redirect_valid = 0;
    step(); step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid actual=%b required=0", out_valid); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_pc actual=%h required=0", out_pc); end
    tests++; if (out_instr !== NOP) begin fails++; $display("FAIL reset_instr actual=%h required=%h", out_instr, NOP); end
    tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL reset_mis actual=%b required=0", misaligned); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr actual=%h required=0", imem_addr); end
  endtask
  task automatic test_stream();
    rst_n = 1; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] actual=%b required=1", i, out_valid); end
      tests++; if (out_pc !== 32'(4*i)) begin fails++; $display("FAIL stream_pc[%0d] actual=%h required=%h", i, out_pc, 32'(4*i)); end
      tests++; if (out_instr !== (32'hA000_0000 | 32'(4*i))) begin fails++; $display("FAIL stream_instr[%0d] actual=%h required=%h", i, out_instr, 32'hA000_0000 | 32'(4*i)); end
    end
  endtask
  task automatic test_stall();
    rst_n = 0; out_ready = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 5; i++) step();
    tests++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL stall_addr actual=%h required=8", imem_addr); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid actual=%b required=1", out_valid); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (out_pc !== 32'(4*i)) begin fails++; $display("FAIL drain_pc[%0d] actual=%h required=%h", i, out_pc, 32'(4*i)); end
      if (i < 2) step();
    end
  endtask
  task automatic test_redirect();
    redirect_valid = 1; redirect_pc = 32'h100;
    step();
    redirect_valid = 0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_valid actual=%b required=0", out_valid); end
    tests++; if (out_instr !== NOP) begin fails++; $display("FAIL redir_instr actual=%h required=%h", out_instr, NOP); end
    tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL redir_addr actual=%h required=100", imem_addr); end
    tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL redir_mis actual=%b required=0", misaligned); end
    step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin fails++; $display("FAIL redir_first actual=%b/%h required=1/100", out_valid, out_pc); end
    tests++; if (out_instr !== 32'hA000_0100) begin fails++; $display("FAIL redir_first_instr actual=%h required=a0000100", out_instr); end
    step();
    tests++; if (out_pc !== 32'h104) begin fails++; $display("FAIL redir_second actual=%h required=104", out_pc); end
  endtask
  task automatic test_misaligned();
    redirect_valid = 1; redirect_pc = 32'h102;
    step();
    redirect_valid = 0;
    tests++; if (misaligned !== 1'b1) begin fails++; $display("FAIL mis_pulse actual=%b required=1", misaligned); end
    tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL mis_addr actual=%h required=100", imem_addr); end
    step();
    tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL mis_clear actual=%b required=0", misaligned); end
    tests++; if (out_pc !== 32'h100) begin fails++; $display("FAIL mis_pc actual=%h required=100", out_pc); end
  endtask
  task automatic test_wrap();
    logic [31:0] exp [3];
    exp[0] = 32'hFFFF_FFF8; exp[1] = 32'hFFFF_FFFC; exp[2] = 32'h0;
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (out_pc !== exp[i]) begin fails++; $display("FAIL wrap_pc[%0d] actual=%h required=%h", i, out_pc, exp[i]); end
      tests++; if (out_instr !== (exp[i] | 32'hA000_0000)) begin fails++; $display("FAIL wrap_instr[%0d] actual=%h required=%h", i, out_instr, exp[i] | 32'hA000_0000); end
    end
  endtask
  task automatic test_back_to_back();
    redirect_valid = 1; redirect_pc = 32'h200;
    step();
    redirect_pc = 32'h300;
    step();
    redirect_valid = 0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid actual=%b required=0", out_valid); end
    tests++; if (imem_addr !== 32'h300) begin fails++; $display("FAIL b2b_addr actual=%h required=300", imem_addr); end
    step();
    tests++; if (out_pc !== 32'h300) begin fails++; $display("FAIL b2b_pc actual=%h required=300", out_pc); end
  endtask
  task automatic test_mid_reset();
    out_ready = 0;
    step(); step(); step();
    tests++; if (imem_addr !== 32'h308) begin fails++; $display("FAIL full_addr actual=%h required=308", imem_addr); end
    rst_n = 0; redirect_valid = 1; redirect_pc = 32'h401; out_ready = 1;
    step();
    rst_n = 1; redirect_valid = 0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_valid actual=%b required=0", out_valid); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL mrst_addr actual=%h required=0", imem_addr); end
    tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL mrst_mis actual=%b required=0", misaligned); end
    step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin fails++; $display("FAIL mrst_first actual=%b/%h required=1/0", out_valid, out_pc); end
    step();
    tests++; if (out_pc !== 32'h4) begin fails++; $display("FAIL mrst_second actual=%h required=4", out_pc); end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
